// File: rtl/otter_cu_fsm.sv
// OTTER multicycle control unit: FETCH / EXEC / WB / INTR sequencer with
// a latched interrupt request and combinational (Mealy) control outputs.
module otter_cu_fsm (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CU_INTR,
  input  logic       CU_MIE,
  input  logic [6:0] CU_OPCODE,
  input  logic [2:0] CU_FUNC3,
  input  logic       CU_BR_EQ,
  input  logic       CU_BR_LT,
  input  logic       CU_BR_LTU,
  output logic       CU_PCWRITE,
  output logic       CU_REGWRITE,
  output logic       CU_MEMRDEN1,
  output logic       CU_MEMRDEN2,
  output logic       CU_MEMWE2,
  output logic       CU_CSR_WE,
  output logic       CU_INT_TAKEN,
  output logic [2:0] CU_PCSOURCE,
  output logic [1:0] CU_STATE
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_WB    = 2'd2;
  localparam logic [1:0] ST_INTR  = 2'd3;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] PC_PLUS4  = 3'd0;
  localparam logic [2:0] PC_JALR   = 3'd1;
  localparam logic [2:0] PC_BRANCH = 3'd2;
  localparam logic [2:0] PC_JAL    = 3'd3;
  localparam logic [2:0] PC_MTVEC  = 3'd4;
  localparam logic [2:0] PC_MEPC   = 3'd5;

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic       intr_pend_reg;
  logic       intr_pend_next;
  logic       intr_go;
  logic       branch_taken;

  logic       pcwrite;
  logic       regwrite;
  logic       memrden1;
  logic       memrden2;
  logic       memwe2;
  logic       csr_we;
  logic       int_taken;
  logic [2:0] pcsource;

  assign intr_go = intr_pend_reg & CU_MIE;

  always_comb begin
    branch_taken = 1'b0;
    case (CU_FUNC3)
      3'b000:  branch_taken = CU_BR_EQ;
      3'b001:  branch_taken = ~CU_BR_EQ;
      3'b100:  branch_taken = CU_BR_LT;
      3'b101:  branch_taken = ~CU_BR_LT;
      3'b110:  branch_taken = CU_BR_LTU;
      3'b111:  branch_taken = ~CU_BR_LTU;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next = ST_FETCH;
    pcwrite    = 1'b0;
    regwrite   = 1'b0;
    memrden1   = 1'b0;
    memrden2   = 1'b0;
    memwe2     = 1'b0;
    csr_we     = 1'b0;
    int_taken  = 1'b0;
    pcsource   = PC_PLUS4;
    case (state_reg)
      ST_FETCH: begin
        memrden1   = 1'b1;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        // Every opcode except LOAD retires here and is an instruction boundary
        pcwrite    = 1'b1;
        state_next = intr_go ? ST_INTR : ST_FETCH;
        case (CU_OPCODE)
          OP_LOAD: begin
            pcwrite    = 1'b0;
            memrden2   = 1'b1;
            state_next = ST_WB;
          end
          OP_STORE:  memwe2 = 1'b1;
          OP_BRANCH: pcsource = branch_taken ? PC_BRANCH : PC_PLUS4;
          OP_JAL: begin
            regwrite = 1'b1;
            pcsource = PC_JAL;
          end
          OP_JALR: begin
            regwrite = 1'b1;
            pcsource = PC_JALR;
          end
          OP_LUI, OP_AUIPC, OP_IMM, OP_OP: regwrite = 1'b1;
          OP_SYSTEM: begin
            if (CU_FUNC3 == 3'b000) begin
              pcsource = PC_MEPC;
            end else begin
              csr_we   = 1'b1;
              regwrite = 1'b1;
            end
          end
          default: ;
        endcase
      end
      ST_WB: begin
        regwrite   = 1'b1;
        pcwrite    = 1'b1;
        state_next = intr_go ? ST_INTR : ST_FETCH;
      end
      default: begin
        int_taken  = 1'b1;
        pcwrite    = 1'b1;
        pcsource   = PC_MTVEC;
        state_next = ST_FETCH;
      end
    endcase
  end

  // Leaving INTR consumes the request even if CU_INTR is still high
  assign intr_pend_next = (state_reg == ST_INTR) ? 1'b0 : (intr_pend_reg | CU_INTR);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= ST_FETCH;
      intr_pend_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      intr_pend_reg <= intr_pend_next;
    end
  end

  // Reset masks every enable so an interrupted instruction commits nothing
  assign CU_PCWRITE   = pcwrite   & ~RST;
  assign CU_REGWRITE  = regwrite  & ~RST;
  assign CU_MEMRDEN1  = memrden1  & ~RST;
  assign CU_MEMRDEN2  = memrden2  & ~RST;
  assign CU_MEMWE2    = memwe2    & ~RST;
  assign CU_CSR_WE    = csr_we    & ~RST;
  assign CU_INT_TAKEN = int_taken & ~RST;
  assign CU_PCSOURCE  = RST ? PC_PLUS4 : pcsource;
  assign CU_STATE     = state_reg;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Scoreboard bench for otter_cu_fsm: each driven cycle queues its expected
// control word; a negedge monitor pops and compares against the DUT.
module tb_otter_cu_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CU_INTR = 1'b0;
  logic       CU_MIE = 1'b0;
  logic [6:0] CU_OPCODE = 7'd0;
  logic [2:0] CU_FUNC3 = 3'd0;
  logic       CU_BR_EQ = 1'b0;
  logic       CU_BR_LT = 1'b0;
  logic       CU_BR_LTU = 1'b0;
  logic       CU_PCWRITE, CU_REGWRITE, CU_MEMRDEN1, CU_MEMRDEN2;
  logic       CU_MEMWE2, CU_CSR_WE, CU_INT_TAKEN;
  logic [2:0] CU_PCSOURCE;
  logic [1:0] CU_STATE;

  otter_cu_fsm dut (
    .CLK(CLK), .RST(RST), .CU_INTR(CU_INTR), .CU_MIE(CU_MIE),
    .CU_OPCODE(CU_OPCODE), .CU_FUNC3(CU_FUNC3),
    .CU_BR_EQ(CU_BR_EQ), .CU_BR_LT(CU_BR_LT), .CU_BR_LTU(CU_BR_LTU),
    .CU_PCWRITE(CU_PCWRITE), .CU_REGWRITE(CU_REGWRITE),
    .CU_MEMRDEN1(CU_MEMRDEN1), .CU_MEMRDEN2(CU_MEMRDEN2),
    .CU_MEMWE2(CU_MEMWE2), .CU_CSR_WE(CU_CSR_WE),
    .CU_INT_TAKEN(CU_INT_TAKEN), .CU_PCSOURCE(CU_PCSOURCE),
    .CU_STATE(CU_STATE)
  );

  always #5 CLK = ~CLK;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, BRANCH = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, LUI = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111, OPIMM = 7'b0010011, OP = 7'b0110011;
  localparam logic [6:0] SYSTEM = 7'b1110011, FENCE = 7'b0001111;

  typedef struct {
    string       name;
    logic [11:0] exp;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Word layout: {state, pcsource, pcwrite, regwrite, rden1, rden2, we2, csr_we, int_taken}
  function automatic logic [11:0] ex(input logic [1:0] st, input logic [2:0] src,
                                     input logic pcw, input logic rw, input logic rd1,
                                     input logic rd2, input logic we2, input logic csr,
                                     input logic it);
    return {st, src, pcw, rw, rd1, rd2, we2, csr, it};
  endfunction

  logic [11:0] W_FETCH, W_ALU, W_NOP, W_INTR, W_ZERO;

  task automatic step(input string name, input logic rst, input logic intr,
                      input logic mie, input logic [6:0] op, input logic [2:0] f3,
                      input logic [2:0] flags, input logic [11:0] exp);
    exp_t e;
    @(posedge CLK);
    #1;
    RST = rst;
    CU_INTR = intr;
    CU_MIE = mie;
    CU_OPCODE = op;
    CU_FUNC3 = f3;
    {CU_BR_EQ, CU_BR_LT, CU_BR_LTU} = flags;
    e.name = name;
    e.exp = exp;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    logic [11:0] got;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        got = {CU_STATE, CU_PCSOURCE, CU_PCWRITE, CU_REGWRITE, CU_MEMRDEN1,
               CU_MEMRDEN2, CU_MEMWE2, CU_CSR_WE, CU_INT_TAKEN};
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("FAIL %s got=%b required=%b", e.name, got, e.exp);
        end else begin
          $display("ok   %s word=%b", e.name, got);
        end
        checks++;
        if (CU_MEMRDEN2 && CU_MEMWE2) begin
          failures++;
          $display("FAIL %s_rd_we_exclusive got=11 required=not both", e.name);
        end
      end
    end
  end

  initial begin : stimulus
    W_FETCH = ex(2'd0, 3'd0, 0, 0, 1, 0, 0, 0, 0);
    W_ALU   = ex(2'd1, 3'd0, 1, 1, 0, 0, 0, 0, 0);
    W_NOP   = ex(2'd1, 3'd0, 1, 0, 0, 0, 0, 0, 0);
    W_INTR  = ex(2'd3, 3'd4, 1, 0, 0, 0, 0, 0, 1);
    W_ZERO  = 12'd0;

    step("reset",        1, 0, 0, OPIMM, 3'd0, 3'b000, W_ZERO);
    // OP_IMM after reset
    step("opimm_fetch",  0, 0, 0, 7'd0,  3'd0, 3'b000, W_FETCH);
    step("opimm_exec",   0, 0, 0, OPIMM, 3'd0, 3'b000, W_ALU);
    // LOAD: three cycles
    step("load_fetch",   0, 0, 0, 7'd0,  3'd0, 3'b000, W_FETCH);
    step("load_exec",    0, 0, 0, LOAD,  3'd2, 3'b000, ex(2'd1, 3'd0, 0, 0, 0, 1, 0, 0, 0));
    step("load_wb",      0, 0, 0, LOAD,  3'd2, 3'b000, ex(2'd2, 3'd0, 1, 1, 0, 0, 0, 0, 0));
    // Branch variants
    step("bge_fetch",    0, 0, 0, 7'd0,   3'd0, 3'b000, W_FETCH);
    step("bge_taken",    0, 0, 0, BRANCH, 3'b101, 3'b000, ex(2'd1, 3'd2, 1, 0, 0, 0, 0, 0, 0));
    step("bge_fetch2",   0, 0, 0, 7'd0,   3'd0, 3'b000, W_FETCH);
    step("bge_not",      0, 0, 0, BRANCH, 3'b101, 3'b010, W_NOP);
    step("b010_fetch",   0, 0, 0, 7'd0,   3'd0, 3'b000, W_FETCH);
    step("b010_never",   0, 0, 0, BRANCH, 3'b010, 3'b111, W_NOP);
    step("beq_fetch",    0, 0, 0, 7'd0,   3'd0, 3'b000, W_FETCH);
    step("beq_taken",    0, 0, 0, BRANCH, 3'b000, 3'b100, ex(2'd1, 3'd2, 1, 0, 0, 0, 0, 0, 0));
    step("bltu_fetch",   0, 0, 0, 7'd0,   3'd0, 3'b000, W_FETCH);
    step("bltu_taken",   0, 0, 0, BRANCH, 3'b110, 3'b001, ex(2'd1, 3'd2, 1, 0, 0, 0, 0, 0, 0));
    // Jumps, upper immediates, system, nop
    step("jal_fetch",    0, 0, 0, 7'd0,  3'd0, 3'b000, W_FETCH);
    step("jal_exec",     0, 0, 0, JAL,   3'd0, 3'b000, ex(2'd1, 3'd3, 1, 1, 0, 0, 0, 0, 0));
    step("jalr_fetch",   0, 0, 0, 7'd0,  3'd0, 3'b000, W_FETCH);
    step("jalr_exec",    0, 0, 0, JALR,  3'd0, 3'b000, ex(2'd1, 3'd1, 1, 1, 0, 0, 0, 0, 0));
    step("lui_fetch",    0, 0, 0, 7'd0,  3'd0, 3'b000, W_FETCH);
    step("lui_exec",     0, 0, 0, LUI,   3'd0, 3'b000, W_ALU);
    step("auipc_fetch",  0, 0, 0, 7'd0,  3'd0, 3'b000, W_FETCH);
    step("auipc_exec",   0, 0, 0, AUIPC, 3'd0, 3'b000, W_ALU);
    step("csrrw_fetch",  0, 0, 0, 7'd0,   3'd0, 3'b000, W_FETCH);
    step("csrrw_exec",   0, 0, 0, SYSTEM, 3'd1, 3'b000, ex(2'd1, 3'd0, 1, 1, 0, 0, 0, 1, 0));
    step("mret_fetch",   0, 0, 0, 7'd0,   3'd0, 3'b000, W_FETCH);
    step("mret_exec",    0, 0, 0, SYSTEM, 3'd0, 3'b000, ex(2'd1, 3'd5, 1, 0, 0, 0, 0, 0, 0));
    step("fence_fetch",  0, 0, 0, 7'd0,  3'd0, 3'b000, W_FETCH);
    step("fence_nop",    0, 0, 0, FENCE, 3'd0, 3'b000, W_NOP);
    // Interrupt pulsed in FETCH, enabled, taken after STORE
    step("irq_fetch",    0, 1, 1, 7'd0,  3'd0, 3'b000, W_FETCH);
    step("irq_store",    0, 0, 1, STORE, 3'd2, 3'b000, ex(2'd1, 3'd0, 1, 0, 0, 0, 1, 0, 0));
    step("irq_intr",     0, 0, 1, 7'd0,  3'd0, 3'b000, W_INTR);
    step("irq_fetch2",   0, 0, 1, 7'd0,  3'd0, 3'b000, W_FETCH);
    step("irq_cleared",  0, 0, 1, OPIMM, 3'd0, 3'b000, W_ALU);
    step("irq_no_reent", 0, 0, 1, 7'd0,  3'd0, 3'b000, W_FETCH);
    // Masked interrupt held across two instructions, taken after the third
    step("mask_exec1",   0, 0, 0, OPIMM, 3'd0, 3'b000, W_ALU);
    step("mask_fetch2",  0, 1, 0, 7'd0,  3'd0, 3'b000, W_FETCH);
    step("mask_exec2",   0, 0, 0, OPIMM, 3'd0, 3'b000, W_ALU);
    step("mask_fetch3",  0, 0, 1, 7'd0,  3'd0, 3'b000, W_FETCH);
    step("mask_exec3",   0, 0, 1, OP,    3'd0, 3'b000, W_ALU);
    step("mask_intr",    0, 0, 1, 7'd0,  3'd0, 3'b000, W_INTR);
    step("mask_fetch4",  0, 0, 1, 7'd0,  3'd0, 3'b000, W_FETCH);
    // Reset during WB of a LOAD with an interrupt pending
    step("rst_exec",     0, 1, 1, LOAD,  3'd2, 3'b000, ex(2'd1, 3'd0, 0, 0, 0, 1, 0, 0, 0));
    step("rst_wb",       1, 0, 1, LOAD,  3'd2, 3'b000, ex(2'd2, 3'd0, 0, 0, 0, 0, 0, 0, 0));
    step("rst_fetch",    0, 0, 1, 7'd0,  3'd0, 3'b000, W_FETCH);
    step("rst_pend_clr", 0, 0, 1, OPIMM, 3'd0, 3'b000, W_ALU);
    step("rst_no_intr",  0, 0, 1, 7'd0,  3'd0, 3'b000, W_FETCH);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge CLK);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog timeout reached required=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/otter_cu_fsm.md
OTTER_CU_FSM -- requirements
Module: otter_cu_fsm

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port RST, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port CU_INTR, input, 1, external interrupt request, level.
REQ-004 SHALL have port CU_MIE, input, 1, machine interrupt enable from CSR file.
REQ-005 SHALL have port CU_OPCODE, input, 7, instruction bits [6:0].
REQ-006 SHALL have port CU_FUNC3, input, 3, instruction bits [14:12].
REQ-007 SHALL have ports CU_BR_EQ, CU_BR_LT, CU_BR_LTU, input, 1 each, branch compare flags (signed LT, unsigned LTU).
REQ-008 SHALL have port CU_PCWRITE, output, 1, PC register load enable.
REQ-009 SHALL have port CU_REGWRITE, output, 1, register-file write enable.
REQ-010 SHALL have port CU_MEMRDEN1, output, 1, instruction-memory read enable.
REQ-011 SHALL have port CU_MEMRDEN2, output, 1, data-memory read enable.
REQ-012 SHALL have port CU_MEMWE2, output, 1, data-memory write enable.
REQ-013 SHALL have port CU_CSR_WE, output, 1, CSR write enable.
REQ-014 SHALL have port CU_INT_TAKEN, output, 1, interrupt entry strobe.
REQ-015 SHALL have port CU_PCSOURCE, output, 3, PC mux select: 0 PC+4, 1 JALR, 2 branch, 3 JAL, 4 mtvec, 5 mepc.
REQ-016 SHALL have port CU_STATE, output, 2, current state encoding (debug).

Function
REQ-017 SHALL implement states FETCH=0, EXEC=1, WB=2, INTR=3 in a 2-bit state register.
REQ-018 SHALL, in FETCH, drive CU_MEMRDEN1=1, all other enables 0, and go to EXEC next cycle.
REQ-019 SHALL, in EXEC with LOAD (0000011), drive CU_MEMRDEN2=1, CU_PCWRITE=0, and go to WB.
REQ-020 SHALL, in WB, drive CU_REGWRITE=1 and CU_PCWRITE=1 with CU_PCSOURCE=0.
REQ-021 SHALL, in EXEC with STORE (0100011), drive CU_MEMWE2=1, CU_PCWRITE=1, CU_PCSOURCE=0.
REQ-022 SHALL, in EXEC with BRANCH (1100011), drive CU_PCWRITE=1 and CU_PCSOURCE=2 if the branch condition holds, else 0.
REQ-023 SHALL evaluate branch condition by CU_FUNC3: 000 EQ, 001 !EQ, 100 LT, 101 !LT, 110 LTU, 111 !LTU, 010/011 false.
REQ-024 SHALL, in EXEC with JAL (1101111)/JALR (1100111), drive CU_REGWRITE=1, CU_PCWRITE=1, CU_PCSOURCE=3/1.
REQ-025 SHALL, in EXEC with LUI, AUIPC, OP_IMM, OP, drive CU_REGWRITE=1, CU_PCWRITE=1, CU_PCSOURCE=0.
REQ-026 SHALL, in EXEC with SYSTEM (1110011) and CU_FUNC3!=000, drive CU_CSR_WE=1, CU_REGWRITE=1, CU_PCWRITE=1, CU_PCSOURCE=0.
REQ-027 SHALL, in EXEC with SYSTEM and CU_FUNC3=000 (mret), drive CU_PCWRITE=1, CU_PCSOURCE=5, CU_REGWRITE=0.
REQ-028 SHALL treat any other opcode as NOP: CU_PCWRITE=1, CU_PCSOURCE=0, other enables 0.
REQ-029 SHALL hold a 1-bit intr_pend register: set on any edge with CU_INTR=1, cleared on the edge leaving INTR; clear wins if both occur.
REQ-030 SHALL, leaving EXEC (non-LOAD) or WB, go to INTR if intr_pend=1 and CU_MIE=1, else FETCH.
REQ-031 SHALL, in INTR, drive CU_INT_TAKEN=1, CU_PCWRITE=1, CU_PCSOURCE=4, other enables 0, and go to FETCH.
REQ-032 SHALL produce all outputs combinationally from state, intr_pend and current inputs (zero added latency).
REQ-033 SHALL hold intr_pend while CU_MIE=0; a later CU_MIE=1 allows entry at the next instruction boundary.
REQ-034 SHALL never assert CU_MEMRDEN2 and CU_MEMWE2 in the same cycle.

Reset
REQ-035 SHALL, on an edge with RST=1, set state=FETCH and intr_pend=0.
REQ-036 SHALL, while RST=1, force CU_PCWRITE, CU_REGWRITE, CU_MEMRDEN1, CU_MEMRDEN2, CU_MEMWE2, CU_CSR_WE, CU_INT_TAKEN to 0 and CU_PCSOURCE to 0.
REQ-037 SHALL, on RST asserted mid-instruction (EXEC or WB), abandon the instruction with no write enable asserted that cycle.

Verification
REQ-038 SHALL cover: OP_IMM after reset -> FETCH(MEMRDEN1=1), EXEC(REGWRITE=1, PCWRITE=1, PCSOURCE=0), then FETCH.
REQ-039 SHALL cover: LOAD -> FETCH, EXEC(MEMRDEN2=1, PCWRITE=0), WB(REGWRITE=1, PCWRITE=1), 3 cycles total.
REQ-040 SHALL cover: BRANCH FUNC3=101 with BR_LT=0 -> PCSOURCE=2; BR_LT=1 -> PCSOURCE=0; FUNC3=010 -> PCSOURCE=0.
REQ-041 SHALL cover: CU_INTR pulsed 1 cycle in FETCH, MIE=1, STORE -> EXEC(MEMWE2=1), INTR(INT_TAKEN=1, PCSOURCE=4), FETCH, intr_pend=0.
REQ-042 SHALL cover: CU_INTR pulsed with MIE=0 for two instructions, then MIE=1 -> INTR entered after the third instruction's EXEC.
REQ-043 SHALL cover: RST=1 during WB of a LOAD -> REGWRITE=0 that cycle, next state FETCH, CU_STATE=0.
